// File: rtl/apb_gpio_pkg.sv
// Shared types and default sizing for the GPIO pad sequencer.
package apb_gpio_pkg;

  localparam int GW_DEF       = 32;
  localparam int TURN_CYC_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    RELEASE,
    TURN,
    DRIVE,
    ENABLE
  } state_t;

endpackage

// File: rtl/gpio_in_sync.sv
// Two-flop pad input synchroniser with per-bit change detect.
// Change pulses are suppressed on bits the block is currently driving.
module gpio_in_sync #(
  parameter int GW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [GW-1:0] in_pad,
  input  logic [GW-1:0] oen_padoe,
  output logic [GW-1:0] in_sync,
  output logic [GW-1:0] in_chg
);

  logic [GW-1:0] meta;
  logic [GW-1:0] in_sync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta      <= '0;
      in_sync   <= '0;
      in_sync_d <= '0;
      in_chg    <= '0;
    end else begin
      meta      <= in_pad;
      in_sync   <= meta;
      in_sync_d <= in_sync;
      in_chg    <= (in_sync ^ in_sync_d) & ~oen_padoe;
    end
  end

endmodule

// File: rtl/apb_gpio_pad_seq.sv
// Pad reconfiguration sequencer: releases outputs first, waits a guard
// interval before turning any input into an output, then drives data and enables.
module apb_gpio_pad_seq
  import apb_gpio_pkg::*;
#(
  parameter int GW       = GW_DEF,
  parameter int TURN_CYC = TURN_CYC_DEF
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [GW-1:0] req_out,
  input  logic [GW-1:0] req_oe,
  output logic [GW-1:0] out_pad,
  output logic [GW-1:0] oen_padoe,
  input  logic [GW-1:0] in_pad,
  output logic [GW-1:0] in_sync,
  output logic [GW-1:0] in_chg,
  output logic          done
);

  state_t        state;
  logic [GW-1:0] tgt_out;
  logic [GW-1:0] tgt_oe;
  logic [GW-1:0] new_en;
  logic [3:0]    cnt;

  assign req_ready = (state == IDLE) && !PRESET;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      tgt_out   <= '0;
      tgt_oe    <= '0;
      new_en    <= '0;
      cnt       <= '0;
      out_pad   <= '0;
      oen_padoe <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            tgt_out <= req_out;
            tgt_oe  <= req_oe;
            new_en  <= req_oe & ~oen_padoe;
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          // Only drop enables here; newly enabled bits wait for the guard.
          oen_padoe <= oen_padoe & tgt_oe;
          if (|new_en) begin
            cnt   <= 4'(TURN_CYC - 1);
            state <= TURN;
          end else begin
            state <= DRIVE;
          end
        end
        TURN: begin
          if (cnt == 4'd0) state <= DRIVE;
          else             cnt   <= cnt - 4'd1;
        end
        DRIVE: begin
          out_pad <= tgt_out;
          state   <= ENABLE;
        end
        ENABLE: begin
          oen_padoe <= tgt_oe;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  gpio_in_sync #(.GW(GW)) u_in_sync (
    .clk       (PCLK),
    .rst       (PRESET),
    .in_pad    (in_pad),
    .oen_padoe (oen_padoe),
    .in_sync   (in_sync),
    .in_chg    (in_chg)
  );

endmodule

// File: tb/tb_apb_gpio_pad_seq.sv
// Scoreboard bench for apb_gpio_pad_seq: stimulus queues expected completions
// and input-change pulses, a negedge monitor pops and compares them.
module tb_apb_gpio_pad_seq;

  localparam int GW = 32;
  localparam int TC = 2;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          req_valid = 1'b0;
  logic [GW-1:0] req_out = '0;
  logic [GW-1:0] req_oe = '0;
  logic [GW-1:0] in_pad = '0;
  logic          req_ready;
  logic          done;
  logic [GW-1:0] out_pad;
  logic [GW-1:0] oen_padoe;
  logic [GW-1:0] in_sync;
  logic [GW-1:0] in_chg;

  apb_gpio_pad_seq #(.GW(GW), .TURN_CYC(TC)) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_out   (req_out),
    .req_oe    (req_oe),
    .out_pad   (out_pad),
    .oen_padoe (oen_padoe),
    .in_pad    (in_pad),
    .in_sync   (in_sync),
    .in_chg    (in_chg),
    .done      (done)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] out;
    logic [31:0] oe;
    int          lat;
    string       name;
  } exp_t;

  typedef struct {
    logic [31:0] val;
    int          t0;
  } chg_t;

  exp_t exp_q[$];
  chg_t chg_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", nm);
  endtask

  initial forever begin
    @(posedge PCLK);
    cyc++;
  end

  // Monitor: latency is counted from the accept edge to the edge that raises done.
  initial begin
    int          outstanding;
    int          accept_edge;
    int          last_fall[GW];
    logic        done_prev;
    logic [31:0] prev_oen;
    logic [31:0] prev_out;
    logic [31:0] rising;
    logic [31:0] viol;
    exp_t        e;
    chg_t        c;
    outstanding = 0;
    accept_edge = 0;
    done_prev = 1'b0;
    prev_oen = '0;
    prev_out = '0;
    for (int i = 0; i < GW; i++) last_fall[i] = -100;
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        outstanding = 0;
        done_prev = 1'b0;
      end else begin
        if (done_prev) chk("done_width", {31'd0, done}, 32'd0);
        if (done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            flag("unexpected_done");
          end else begin
            e = exp_q.pop_front();
            $display("txn %s: out_pad=%h oen_padoe=%h lat=%0d", e.name, out_pad, oen_padoe,
                     cyc - accept_edge);
            chk({e.name, "_out"}, out_pad, e.out);
            chk({e.name, "_oe"}, oen_padoe, e.oe);
            chk({e.name, "_lat"}, 32'(cyc - accept_edge), 32'(e.lat));
          end
          outstanding = 0;
        end
        if (req_valid && req_ready) begin
          accept_cnt++;
          chk("accept_while_busy", 32'(outstanding), 32'd0);
          outstanding = 1;
          accept_edge = cyc + 1;
        end
        rising = oen_padoe & ~prev_oen;
        for (int i = 0; i < GW; i++)
          if (prev_oen[i] && !oen_padoe[i]) last_fall[i] = cyc;
        if (rising != 0) begin
          viol = '0;
          for (int i = 0; i < GW; i++)
            if (rising[i] && (cyc - last_fall[i] <= TC)) viol[i] = 1'b1;
          chk("turn_guard", viol, 32'd0);
          chk("drive_before_enable", out_pad & rising, prev_out & rising);
        end
        if (in_chg != 0) begin
          if (chg_q.size() == 0) begin
            flag("unexpected_in_chg");
          end else begin
            c = chg_q.pop_front();
            $display("txn in_chg: value=%h delay=%0d", in_chg, cyc - c.t0);
            chk("in_chg_val", in_chg, c.val);
            chk("in_chg_delay", 32'(cyc - c.t0), 32'd3);
          end
        end
        done_prev = done;
      end
      prev_oen = oen_padoe;
      prev_out = out_pad;
    end
  end

  task automatic do_req(input string nm, input logic [31:0] o, input logic [31:0] oe,
                        input int lat, input logic [31:0] rel);
    int n;
    int start;
    @(posedge PCLK) #1;
    req_out = o;
    req_oe = oe;
    req_valid = 1'b1;
    exp_q.push_back('{o, oe, lat, nm});
    start = done_cnt;
    n = 0;
    @(negedge PCLK) #1;
    while (!req_ready && n < 20) begin
      @(negedge PCLK) #1;
      n++;
    end
    if (!req_ready) flag({nm, "_accept_timeout"});
    @(posedge PCLK) #1;
    req_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk({nm, "_release"}, oen_padoe, rel);
    n = 0;
    while (done_cnt == start && n < 20) begin
      @(negedge PCLK) #1;
      n++;
    end
    if (done_cnt == start) flag({nm, "_done_timeout"});
  endtask

  initial begin
    int n;
    int start_acc;
    int start_done;
    repeat (3) @(negedge PCLK);
    chk("rst_out_pad", out_pad, 32'd0);
    chk("rst_oen", oen_padoe, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_in_sync", in_sync, 32'd0);
    chk("rst_in_chg", in_chg, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    @(posedge PCLK) #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    do_req("all_on",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'h0000_0000);
    do_req("all_off", 32'h0000_0000, 32'h0000_0000, 3, 32'h0000_0000);
    do_req("low_on",  32'h1234_5678, 32'h0000_FFFF, 5, 32'h0000_0000);
    do_req("swap",    32'hA5A5_0000, 32'hFFFF_0000, 5, 32'h0000_0000);
    do_req("same",    32'hA5A5_0000, 32'hFFFF_0000, 3, 32'hFFFF_0000);

    // req_valid held through two complete sequences
    @(posedge PCLK) #1;
    req_out = 32'h0F0F_0F0F;
    req_oe = 32'hFFFF_FFFF;
    req_valid = 1'b1;
    exp_q.push_back('{32'h0F0F_0F0F, 32'hFFFF_FFFF, 5, "held1"});
    exp_q.push_back('{32'h0F0F_0F0F, 32'hFFFF_FFFF, 3, "held2"});
    start_acc = accept_cnt;
    start_done = done_cnt;
    n = 0;
    while (accept_cnt < start_acc + 2 && n < 40) begin
      @(negedge PCLK) #1;
      n++;
    end
    if (accept_cnt < start_acc + 2) flag("held_accept_timeout");
    @(posedge PCLK) #1;
    req_valid = 1'b0;
    n = 0;
    while (done_cnt < start_done + 2 && n < 20) begin
      @(negedge PCLK) #1;
      n++;
    end
    chk("held_dones", 32'(done_cnt - start_done), 32'd2);
    chk("held_accepts", 32'(accept_cnt - start_acc), 32'd2);

    // input change on an undriven pad
    do_req("in_mode", 32'h0000_0000, 32'h0000_0000, 3, 32'h0000_0000);
    @(posedge PCLK) #1;
    in_pad[3] = 1'b1;
    chg_q.push_back('{32'h0000_0008, cyc});
    repeat (6) @(negedge PCLK);
    #1;
    chk("chg_seen", 32'(chg_q.size()), 32'd0);
    chk("in_sync_bit3", in_sync, 32'h0000_0008);

    // same toggle with bit 3 driven must be masked
    do_req("drv3", 32'h0000_0008, 32'h0000_0008, 5, 32'h0000_0000);
    @(posedge PCLK) #1;
    in_pad[3] = 1'b0;
    repeat (6) begin
      @(negedge PCLK) #1;
      chk("chg_masked", in_chg, 32'd0);
    end

    // reset while in TURN
    @(posedge PCLK) #1;
    req_out = 32'h0000_FFFF;
    req_oe = 32'hFFFF_FFFF;
    req_valid = 1'b1;
    exp_q.push_back('{32'h0000_FFFF, 32'hFFFF_FFFF, 5, "aborted"});
    start_done = done_cnt;
    @(negedge PCLK);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    @(posedge PCLK) #1;
    req_valid = 1'b0;
    @(posedge PCLK) #3;
    chk("pre_rst_oen", oen_padoe, 32'h0000_0008);
    PRESET = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_oen", oen_padoe, 32'd0);
    chk("mid_rst_out", out_pad, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    repeat (8) @(negedge PCLK);
    #1;
    chk("no_done_after_abort", 32'(done_cnt - start_done), 32'd0);

    do_req("after_rst", 32'hCAFE_F00D, 32'hFFFF_FFFF, 5, 32'h0000_0000);

    repeat (4) @(negedge PCLK);
    #1;
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("chg_q_empty", 32'(chg_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
